// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seg7_pkg;

    // Scan controller FSM states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // All segments (and the decimal point) off; segments are active-low.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Hex glyphs 0..F, active-low, bit 7 (dp) held at 1, bits 6:0 = g..a.
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern, with decimal point and blanking.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble_i (hex value), dp_i (decimal point on), blank_i (force all off),
//        seg_o (active-low, bit 7 = dp, bits 6:0 = g..a).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        if (blank_i) begin
            seg_o = SEG_OFF;
        end else begin
            seg_o = {~dp_i, GLYPH[nibble_i][6:0]};
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display scanner with frame snapshot, leading-zero blanking and PWM dimming.
// Latency: seg/grid registered, one cycle behind the slot/digit counters; frame_tick registered.
// Backpressure: none; the display free-runs while en=1 and blanks on the edge after en=0.
// Ports: clk, reset_n (async active-low), en, in_data (MS nibble = digit 0), dp, blank_lz,
//        brightness -> seg (active-low), grid (active-low, MSB = digit 0), frame_tick.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int PWM_BITS    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   in_data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      blank_lz,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     grid,
    output logic                      frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Cycles per brightness step within a slot.
    localparam int STEP  = REFRESH_DIV >> PWM_BITS;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          slot_q, slot_d;
    logic [DIG_W-1:0]          digit_q, digit_d;
    logic                      frame_start;
    logic                      slot_wrap, digit_wrap;

    logic [4*NUM_DIGITS-1:0]   snap_data_q;
    logic [NUM_DIGITS-1:0]     snap_dp_q;
    logic                      snap_lz_q;
    logic [PWM_BITS-1:0]       snap_br_q;

    logic [NUM_DIGITS-1:0]     lz_blank;
    logic                      zero_run;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_blank;
    logic [NUM_DIGITS-1:0]     lit_grid;
    logic [CNT_W-1:0]          phase;
    logic                      pwm_on;
    logic                      scan_live;
    logic [7:0]                dec_seg;

    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     grid_q, grid_d;
    logic                      tick_q;

    assign slot_wrap  = (slot_q == CNT_W'(REFRESH_DIV - 1));
    assign digit_wrap = (digit_q == DIG_W'(NUM_DIGITS - 1));

    // Counter/FSM next state. Dropping en returns to IDLE on the next edge with
    // counters cleared, so re-enabling always starts a fresh frame at digit 0.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        digit_d     = digit_q;
        frame_start = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            digit_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d     = ST_SCAN;
            slot_d      = '0;
            digit_d     = '0;
            frame_start = 1'b1;
        end else if (slot_wrap) begin
            slot_d = '0;
            if (digit_wrap) begin
                digit_d     = '0;
                frame_start = 1'b1;
            end else begin
                digit_d = digit_q + 1'b1;
            end
        end else begin
            slot_d = slot_q + 1'b1;
        end
    end

    // Leading-zero blanking: digit k is blanked while every nibble from the left
    // up to and including k is zero. The rightmost digit always shows.
    always_comb begin
        lz_blank = '0;
        zero_run = snap_lz_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_run    = zero_run & (snap_data_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            lz_blank[k] = zero_run & (k != NUM_DIGITS - 1);
        end
    end

    // Select the snapshot fields of the digit currently being scanned.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        lit_grid  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_q == DIG_W'(k)) begin
                cur_nib                    = snap_data_q[4*(NUM_DIGITS-1-k) +: 4];
                cur_dp                     = snap_dp_q[NUM_DIGITS-1-k];
                cur_blank                  = lz_blank[k];
                lit_grid[NUM_DIGITS-1-k]   = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .blank_i  (cur_blank),
        .seg_o    (dec_seg)
    );

    // Slot cycle 0 is always dark so the previous digit's anode is off before
    // the next one turns on (anti-ghosting).
    assign phase     = slot_q / CNT_W'(STEP);
    assign pwm_on    = (slot_q != '0) && (phase < CNT_W'(snap_br_q));
    assign scan_live = (state_q == ST_SCAN) && en;

    always_comb begin
        seg_d  = SEG_OFF;
        grid_d = '1;
        if (scan_live) begin
            seg_d = dec_seg;
            if (pwm_on) begin
                grid_d = lit_grid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            digit_q     <= '0;
            snap_data_q <= '0;
            snap_dp_q   <= '0;
            snap_lz_q   <= 1'b0;
            snap_br_q   <= '0;
            seg_q       <= SEG_OFF;
            grid_q      <= '1;
            tick_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            grid_q  <= grid_d;
            tick_q  <= frame_start;
            if (frame_start) begin
                snap_data_q <= in_data;
                snap_dp_q   <= dp;
                snap_lz_q   <= blank_lz;
                snap_br_q   <= brightness;
            end
        end
    end

    assign seg        = seg_q;
    assign grid       = grid_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; SHALL be a multiple of 2**PWM_BITS and at least 2**PWM_BITS.
REQ-003 Parameter PWM_BITS, default 4: width of the brightness control.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  scan enable; 0 blanks the display.
REQ-007 in_data  in  4*NUM_DIGITS  hex value; the MS nibble is digit 0 (leftmost).
REQ-008 dp  in  NUM_DIGITS  per-digit decimal point; bit NUM_DIGITS-1 is digit 0.
REQ-009 blank_lz  in  1  leading-zero suppression enable.
REQ-010 brightness  in  PWM_BITS  on-time in 1/2**PWM_BITS slot units.
REQ-011 seg  out  8  active-low segments: bit 7 = dp, bits 6:0 = g..a.
REQ-012 grid  out  NUM_DIGITS  active-low anodes; bit NUM_DIGITS-1 is digit 0.
REQ-013 frame_tick  out  1  one-cycle pulse at each frame start.

Function
REQ-014 The FSM SHALL have two states: IDLE and SCAN. IDLE moves to SCAN on en=1. SCAN moves to IDLE on en=0, effective on the next edge.
REQ-015 In IDLE:
- grid = all 1s, seg = 8'hFF, frame_tick = 0.
- The slot counter and the digit index SHALL be held at 0.
REQ-016 In SCAN, the slot counter SHALL count 0..REFRESH_DIV-1 and then wrap. On each wrap, the digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-017 Frame start is the first SCAN cycle after IDLE, or any cycle where the slot counter and digit index both wrap to 0. At frame start:
- in_data, dp, blank_lz and brightness SHALL be captured into snapshot registers.
- frame_tick SHALL pulse.
REQ-018 All display output SHALL come from the snapshot only. Input changes mid-frame SHALL NOT appear until the next frame.
REQ-019 Leading-zero suppression is active when snapshot blank_lz=1. Digit k SHALL be blanked (seg=8'hFF, dp suppressed) when nibbles 0..k are all zero. The last digit (NUM_DIGITS-1) SHALL never be blanked.
REQ-020 PWM phase = slot counter / (REFRESH_DIV >> PWM_BITS). The active grid bit SHALL be 0 only while phase < snapshot brightness. brightness=0 keeps the display dark for the whole frame.
REQ-021 seg and grid SHALL be registered, lagging the counter state by exactly 1 cycle.
REQ-022 At most one grid bit SHALL be 0 in any cycle.
REQ-023 During a digit change, grid SHALL be all 1s for the first cycle of each slot (anti-ghosting) when brightness is nonzero.
REQ-024 The decoder SHALL map 0-F to the standard hex glyphs: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E. These values are bits 6:0 with bit 7=1. seg[7]=~dp when the digit is not blanked.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately set:
- state = IDLE, counters = 0, snapshots = 0;
- grid = all 1s, seg = 8'hFF, frame_tick = 0.
REQ-026 Reset mid-frame SHALL discard the frame. After release with en=1, scanning SHALL restart at digit 0 with a fresh snapshot.

Structure
REQ-027 Package seg7_pkg SHALL hold:
- the state enum;
- the 16-entry glyph constant table;
- the SEG_OFF=8'hFF constant.
REQ-028 A sub-module seg7_decode SHALL be used: combinational, 4-bit nibble + dp + blank in, 8-bit seg out.

Verification
REQ-029 All scenarios use NUM_DIGITS=4, REFRESH_DIV=16, PWM_BITS=2.
REQ-030 Basic scan: in_data=16'h12AF, brightness=3, en=1 -> grid cycles 0111, 1011, 1101, 1110. seg = F9, A4, 88, 8E. Each digit is lit for cycles 1..11 of its 16-cycle slot.
REQ-031 Leading-zero suppression: in_data=16'h0040, blank_lz=1, dp=4'b1000 -> digits 0 and 1 show FF. Digits 2 and 3 show 99 and C0. The dp on digit 0 is suppressed.
REQ-032 All zeros: in_data=16'h0000, blank_lz=1 -> digits 0-2 show FF; digit 3 shows C0.
REQ-033 Snapshot: change in_data from 16'h1111 to 16'h2222 during digit 1 -> digits 1-3 still show F9. The next frame_tick then all digits show A4.
REQ-034 Brightness and enable:
- brightness=0 -> grid stays 1111 for the whole frame;
- en=0 mid-slot -> grid = 1111 after the next edge;
- en=1 again -> frame_tick pulses and digit 0 restarts.
REQ-035 Async reset: reset_n=0 mid-slot -> grid=1111 and seg=FF with no clock edge required. After release, the first frame_tick arrives 1 cycle after en=1.
